// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the two-master memory bus
//               arbiter: FSM state encoding, master index constants and the
//               starvation-counter width.
// Revision    : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

  // Arbiter/sequencer state encoding
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Master index constants
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // Width of the starvation counter; STARVE_LIMIT must fit (1..7)
  localparam int STARVE_W = 3;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arb_select.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_select
// Description : Combinational winner selection. Master 0 has fixed priority
//               unless master 1 has been passed over STARVE_LIMIT times in a
//               row, in which case master 1 wins.
// Ports       : req0_i, req1_i   - master requests
//               starve_cnt_i     - consecutive master-0 grants with m1 waiting
//               grant_o          - winning master index (M0/M1)
//               grant_valid_o    - at least one request is pending
// Revision    : 1.0  initial release
// ============================================================================
module mem_arb_select
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                req0_i,
  input  logic                req1_i,
  input  logic [STARVE_W-1:0] starve_cnt_i,
  output logic                grant_o,
  output logic                grant_valid_o
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  always_comb begin
    grant_valid_o = req0_i | req1_i;
    grant_o       = M0;
    // Master 1 wins when alone, or when master 0 has used up its streak
    if (req1_i && (!req0_i || (starve_cnt_i == LIMIT))) begin
      grant_o = M1;
    end
  end

endmodule : mem_arb_select
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Two-master arbiter and access sequencer for the single-ported
//               data memory / peripheral bus. One request is latched per
//               IDLE -> ACCESS -> DONE pass: a single read or write strobe in
//               ACCESS, a one-cycle ack to the winner in DONE.
// Ports       : clk, reset (async, active-high)
//               m0_* / m1_* - master request/ack/data channels
//               mem_*       - registered memory bus, mem_rdata combinational in
// Revision    : 1.0  initial release
// ============================================================================
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  state_e                state_q, state_d;
  logic                  win_q, win_d;
  logic                  wr_q, wr_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata0_q, rdata0_d;
  logic [31:0]           rdata1_q, rdata1_d;
  logic [STARVE_W-1:0]   starve_q, starve_d;
  logic                  read_q, read_d;
  logic                  write_q, write_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic                  w_grant;
  logic                  w_grant_valid;

  mem_arb_select #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_select (
    .req0_i        (m0_req),
    .req1_i        (m1_req),
    .starve_cnt_i  (starve_q),
    .grant_o       (w_grant),
    .grant_valid_o (w_grant_valid)
  );

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    starve_d = starve_q;
    read_d   = 1'b0;
    write_d  = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (w_grant_valid) begin
          state_d = ACCESS;
          win_d   = w_grant;
          if (w_grant == M1) begin
            wr_d     = m1_wr;
            addr_d   = m1_addr;
            wdata_d  = m1_wdata;
            read_d   = !m1_wr;
            write_d  = m1_wr;
            starve_d = '0;
          end else begin
            wr_d    = m0_wr;
            addr_d  = m0_addr;
            wdata_d = m0_wdata;
            read_d  = !m0_wr;
            write_d = m0_wr;
            // Only a master-0 grant that passes over a waiting master 1 counts
            if (m1_req) begin
              starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 1'b1;
            end else begin
              starve_d = '0;
            end
          end
        end
      end
      ACCESS: begin
        state_d = DONE;
        // mem_rdata is valid from mem_addr during this cycle; capture on exit
        if (!wr_q) begin
          if (win_q == M1) rdata1_d = mem_rdata;
          else             rdata0_d = mem_rdata;
        end
        ack0_d = (win_q == M0);
        ack1_d = (win_q == M1);
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      win_q    <= M0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      starve_q <= '0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      starve_q <= starve_d;
      read_q   <= read_d;
      write_q  <= write_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
    end
  end

  assign mem_read  = read_q;
  assign mem_write = write_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign m0_ack    = ack0_q;
  assign m1_ack    = ack1_q;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;

endmodule : mem_bus_arbiter
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Directed self-checking bench for mem_bus_arbiter: reset state,
//               single read, simultaneous requests, starvation bound,
//               abandoned request, reset mid-access and idle bus.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .STARVE_LIMIT (4)
  ) dut (
    .clk       (clk),
    .reset     (rst),
    .m0_req    (m0_req),
    .m0_wr     (m0_wr),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_ack    (m0_ack),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_wr     (m1_wr),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_ack    (m1_ack),
    .m1_rdata  (m1_rdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected winner per grant with both masters requesting (1 = master 1)
  logic [9:0] exp_win;

  initial begin
    rst       = 1'b1;
    m0_req    = 1'b0; m0_wr = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req    = 1'b0; m1_wr = 1'b0; m1_addr = '0; m1_wdata = '0;
    mem_rdata = '0;
    exp_win   = 10'b1000010000;   // bit g = grant g: 0,0,0,0,1,0,0,0,0,1

    // ---------------- reset state ----------------
    #12;
    check("rst_mem_read",  {31'd0, mem_read},  32'd0);
    check("rst_mem_write", {31'd0, mem_write}, 32'd0);
    check("rst_acks",      {30'd0, m0_ack, m1_ack}, 32'd0);
    check("rst_mem_addr",  mem_addr, 32'd0);
    check("rst_m0_rdata",  m0_rdata, 32'd0);
    tick;
    rst = 1'b0;

    // ---------------- single read by m0 ----------------
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 32'h0000_0010;
    mem_rdata = 32'hDEAD_BEEF;
    tick;   // ACCESS
    check("rd_mem_read",  {31'd0, mem_read},  32'd1);
    check("rd_mem_write", {31'd0, mem_write}, 32'd0);
    check("rd_mem_addr",  mem_addr, 32'h0000_0010);
    check("rd_no_ack_yet", {31'd0, m0_ack}, 32'd0);
    tick;   // DONE
    check("rd_m0_ack",   {31'd0, m0_ack}, 32'd1);
    check("rd_m1_ack",   {31'd0, m1_ack}, 32'd0);
    check("rd_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    check("rd_strobe_off", {31'd0, mem_read}, 32'd0);
    m0_req = 1'b0;
    tick;   // IDLE
    check("rd_ack_single", {31'd0, m0_ack}, 32'd0);
    check("rd_rdata_hold", m0_rdata, 32'hDEAD_BEEF);

    // ---------------- simultaneous requests ----------------
    m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 32'h4000_000C; m0_wdata = 32'h0000_00A5;
    m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 32'h0000_0020;
    mem_rdata = 32'h1111_2222;
    tick;   // ACCESS (m0 write)
    check("sim_m0_write", {31'd0, mem_write}, 32'd1);
    check("sim_m0_noread", {31'd0, mem_read}, 32'd0);
    check("sim_m0_addr",  mem_addr,  32'h4000_000C);
    check("sim_m0_wdata", mem_wdata, 32'h0000_00A5);
    tick;   // DONE (m0)
    check("sim_m0_ack", {30'd0, m0_ack, m1_ack}, 32'd2);
    m0_req = 1'b0;
    tick;   // IDLE
    check("sim_gap_quiet", {28'd0, mem_read, mem_write, m0_ack, m1_ack}, 32'd0);
    tick;   // ACCESS (m1 read)
    check("sim_m1_read", {31'd0, mem_read}, 32'd1);
    check("sim_m1_addr", mem_addr, 32'h0000_0020);
    tick;   // DONE (m1), three cycles after m0_ack
    check("sim_m1_ack", {30'd0, m0_ack, m1_ack}, 32'd1);
    check("sim_m1_rdata", m1_rdata, 32'h1111_2222);
    check("sim_m0_rdata_kept", m0_rdata, 32'hDEAD_BEEF);
    m1_req = 1'b0;
    tick;   // IDLE

    // ---------------- starvation bound ----------------
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 32'h0000_0100;
    m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 32'h0000_0200;
    mem_rdata = 32'h0000_0055;
    for (int g = 0; g < 10; g++) begin
      tick;   // ACCESS
      check($sformatf("stv_addr_%0d", g), mem_addr,
            exp_win[g] ? 32'h0000_0200 : 32'h0000_0100);
      tick;   // DONE
      check($sformatf("stv_acks_%0d", g), {30'd0, m0_ack, m1_ack},
            exp_win[g] ? 32'd1 : 32'd2);
      if (g == 9) begin
        m0_req = 1'b0;
        m1_req = 1'b0;
      end
      tick;   // IDLE
    end

    // ---------------- abandoned request ----------------
    m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 32'h0000_0030; m1_wdata = 32'h1234_5678;
    tick;   // ACCESS
    m1_req = 1'b0;
    check("abn_write", {31'd0, mem_write}, 32'd1);
    check("abn_noread", {31'd0, mem_read}, 32'd0);
    check("abn_addr",  mem_addr,  32'h0000_0030);
    check("abn_wdata", mem_wdata, 32'h1234_5678);
    tick;   // DONE
    check("abn_ack", {30'd0, m0_ack, m1_ack}, 32'd1);
    check("abn_rdata_unchanged", m1_rdata, 32'h0000_0055);
    tick;   // IDLE
    check("abn_ack_single", {31'd0, m1_ack}, 32'd0);
    tick;
    check("abn_no_reissue", {28'd0, mem_read, mem_write, m0_ack, m1_ack}, 32'd0);

    // ---------------- reset mid-access ----------------
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 32'h0000_0040;
    mem_rdata = 32'hCAFE_F00D;
    tick;   // ACCESS
    check("mrst_pre_read", {31'd0, mem_read}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mrst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    check("mrst_acks",    {30'd0, m0_ack, m1_ack}, 32'd0);
    check("mrst_m0_rdata", m0_rdata, 32'd0);
    check("mrst_m1_rdata", m1_rdata, 32'd0);
    check("mrst_mem_addr", mem_addr, 32'd0);
    m0_req = 1'b0;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      check($sformatf("mrst_quiet_%0d", i),
            {28'd0, mem_read, mem_write, m0_ack, m1_ack}, 32'd0);
    end

    // ---------------- idle bus ----------------
    for (int i = 0; i < 20; i++) begin
      tick;
      check($sformatf("idle_quiet_%0d", i),
            {28'd0, mem_read, mem_write, m0_ack, m1_ack}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_mem_bus_arbiter
`default_nettype wire

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter and access sequencer for the single-ported data memory/peripheral bus (DataMem plus its LED, switch, digit and UART registers). Master 0 is the CPU load/store path. Master 1 is a secondary bus master, such as a UART receive-to-memory DMA. The block registers one request at a time, drives exactly one memory read or write strobe, captures the read data and returns a one-cycle acknowledge. Master 0 has fixed priority, bounded by a starvation limit that guarantees master 1 progress.

## Interface
- STARVE_LIMIT, 4: consecutive master-0 grants allowed while master 1 is waiting; range 1–7.
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high reset
- m0_req  in  1  master 0 request; held high until m0_ack
- m0_wr  in  1  master 0: 1 = write, 0 = read
- m0_addr  in  32  master 0 byte address, passed through unchanged
- m0_wdata  in  32  master 0 write data
- m0_ack  out  1  one-cycle completion pulse to master 0
- m0_rdata  out  32  master 0 read data, valid while m0_ack is high
- m1_req, m1_wr, m1_addr, m1_wdata, m1_ack, m1_rdata: identical to the master 0 signals, for master 1
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  32  registered access address
- mem_wdata  out  32  registered write data
- mem_rdata  in  32  memory read data, combinational from mem_addr

## Operation
- States:
  - IDLE: sample requests, choose a winner, latch its wr/addr/wdata and the winner index.
  - ACCESS: drive the strobe for the latched access.
  - DONE: pulse the winner's ack.
- IDLE → ACCESS when any req is high at the edge; otherwise stay in IDLE.
- ACCESS → DONE always. DONE → IDLE always.
- Winner selection in IDLE:
  - Only one req high: that master wins.
  - Both req high: master 0 wins unless starve_cnt == STARVE_LIMIT, in which case master 1 wins.
- starve_cnt (3 bits) updates at each grant:
  - Master 0 granted while m1_req is high: starve_cnt + 1, saturating at STARVE_LIMIT.
  - Any master-1 grant, or a master-0 grant with m1_req low: starve_cnt ← 0.
- ACCESS:
  - mem_write = latched wr; mem_read = !latched wr.
  - mem_read and mem_write are never high together.
  - For a read, mem_rdata is captured into the winner's rdata register at the ACCESS→DONE edge.
- DONE:
  - Winner's ack = 1; the other ack = 0.
  - The winner's rdata holds the captured value and stays valid until that master's next read.
  - rdata after a write is unchanged.
- Requests are ignored in ACCESS and DONE. The loser keeps req high and is re-arbitrated in the next IDLE.
- A request dropped after being latched still completes: the strobe is issued and the ack pulses anyway.
- Reset, including reset asserted mid-access:
  - All outputs go to 0 immediately and the state goes to IDLE.
  - starve_cnt and both rdata registers clear to 0.
  - An aborted access issues no further strobe and no ack.

## Timing
- Latency: req high at edge N (IDLE) → strobe during cycle N+1 → ack during cycle N+2.
- Per-transaction occupancy is 3 cycles; maximum bus throughput is one access per 3 cycles.
- The requester must drop req in the cycle after its ack. A req still high at the following IDLE edge is a new request.
- mem_addr, mem_wdata, mem_read and mem_write all come from registers. There is no combinational path from any m*_ input to any mem_* output.
- Read data path: mem_rdata must settle within the ACCESS cycle (single-cycle DataMem read).

## Structure
- Package mem_arb_pkg holds:
  - the state encoding (IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2);
  - the master index constants M0 = 1'b0 and M1 = 1'b1;
  - the starvation-counter width.
- One sub-module, mem_arb_select. It is purely combinational: it takes both reqs, starve_cnt and STARVE_LIMIT, and outputs the grant index and a grant-valid flag.
- The FSM, the latches and the rdata capture stay in the top module.

## Test plan
- Single read: m0 reads 0x00000010 with mem_rdata = 0xDEADBEEF → mem_read high one cycle with mem_addr = 0x10; m0_ack and m0_rdata = 0xDEADBEEF two cycles after the sampling edge.
- Simultaneous requests: m0 writes 0x4000000C ← 0x000000A5 while m1 reads 0x20 → m0 is served first with one mem_write pulse; m1 is served next, and m1_ack arrives 3 cycles after m0_ack.
- Starvation bound: STARVE_LIMIT = 4, m0_req held continuously and m1_req held → exactly 4 m0 grants, then 1 m1 grant, then m0 resumes; starve_cnt returns to 0.
- Abandoned request: m1 drops req during ACCESS of a write to 0x30 ← 0x12345678 → the mem_write pulse still occurs and m1_ack still pulses once.
- Reset mid-access: assert reset while in ACCESS → mem_read, mem_write, both acks and both rdata outputs are 0 immediately; after release with no reqs, the block stays in IDLE and issues no strobe.
- Idle bus: no reqs for 20 cycles → mem_read = mem_write = 0 throughout and no ack pulses.
